// File: rtl/stim_sequencer.sv
// Stimulus sequencer: writable pattern memory replayed as gap/hold windows
// over one test pass or several training epochs, with pause and abort control.
module stim_sequencer #(
  parameter int P_VEC_W  = 25,
  parameter int P_LBL_W  = 10,
  parameter int P_DEPTH  = 30,
  parameter int P_HOLD   = 1,
  parameter int P_GAP    = 200,
  parameter int P_EPOCHS = 400,
  localparam int AW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1,
  localparam int EW = $clog2(P_EPOCHS + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic [AW-1:0]              i_wr_addr,
  input  logic [P_VEC_W+P_LBL_W-1:0] i_wr_data,
  input  logic                       i_start,
  input  logic                       i_mode,
  input  logic                       i_pause,
  input  logic                       i_abort,
  output logic [P_VEC_W-1:0]         o_vector,
  output logic [P_LBL_W-1:0]         o_label,
  output logic                       o_valid,
  output logic [AW-1:0]              o_index,
  output logic [EW-1:0]              o_epoch,
  output logic                       o_epoch_end,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int DW = P_VEC_W + P_LBL_W;
  localparam int GW = (P_GAP > 1) ? $clog2(P_GAP) : 1;
  localparam int HW = (P_HOLD > 1) ? $clog2(P_HOLD) : 1;
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(P_DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(P_DEPTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(P_GAP - 1);
  localparam logic [HW-1:0] HLD_LAST = HW'(P_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GAP, HOLD} state_t;

  state_t          state_reg;
  logic [GW-1:0]   gap_cnt_reg;
  logic [HW-1:0]   hold_cnt_reg;
  logic            mode_reg;
  logic [DW-1:0]   mem [P_DEPTH];
  logic [DW-1:0]   rd_word;
  logic [EW-1:0]   target;

  assign rd_word = mem[o_index];
  assign target  = mode_reg ? EW'(1) : EW'(P_EPOCHS);

  // Contents are deliberately not reset so a stored pattern set survives reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en && ({1'b0, i_wr_addr} < DEPTH_W))
      mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      gap_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
      mode_reg     <= 1'b0;
      o_vector     <= '0;
      o_label      <= '0;
      o_valid      <= 1'b0;
      o_index      <= '0;
      o_epoch      <= '0;
      o_epoch_end  <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_epoch_end <= 1'b0;
      if (i_abort) begin
        state_reg <= IDLE;
        o_vector  <= '0;
        o_label   <= '0;
        o_valid   <= 1'b0;
        o_busy    <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (i_start) begin
              state_reg   <= GAP;
              o_busy      <= 1'b1;
              o_epoch     <= '0;
              o_index     <= '0;
              o_done      <= 1'b0;
              gap_cnt_reg <= '0;
              mode_reg    <= i_mode;
            end
          end
          GAP: begin
            if (!i_pause) begin
              // The memory word is captured straight into the output register,
              // so a same-edge write is seen only by later windows.
              if (gap_cnt_reg == GAP_LAST) begin
                state_reg    <= HOLD;
                hold_cnt_reg <= '0;
                o_valid      <= 1'b1;
                o_vector     <= rd_word[DW-1 -: P_VEC_W];
                o_label      <= mode_reg ? '0 : rd_word[P_LBL_W-1:0];
              end else begin
                gap_cnt_reg <= gap_cnt_reg + 1'b1;
              end
            end
          end
          HOLD: begin
            if (hold_cnt_reg == HLD_LAST) begin
              o_valid     <= 1'b0;
              o_vector    <= '0;
              o_label     <= '0;
              gap_cnt_reg <= '0;
              if (o_index != LAST_IDX) begin
                o_index   <= o_index + 1'b1;
                state_reg <= GAP;
              end else begin
                o_epoch_end <= 1'b1;
                o_epoch     <= o_epoch + 1'b1;
                if (o_epoch + EW'(1) == target) begin
                  state_reg <= IDLE;
                  o_busy    <= 1'b0;
                  o_done    <= 1'b1;
                end else begin
                  o_index   <= '0;
                  state_reg <= GAP;
                end
              end
            end else begin
              hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stim_sequencer.sv
// Randomized bench for stim_sequencer: expected output trace per run is built
// from the gap/hold/epoch rules, then compared cycle by cycle.
module tb_stim_sequencer;
  localparam int P_VEC_W  = 25;
  localparam int P_LBL_W  = 10;
  localparam int P_DEPTH  = 3;
  localparam int P_HOLD   = 2;
  localparam int P_GAP    = 4;
  localparam int P_EPOCHS = 2;
  localparam int AW = 2;
  localparam int EW = 2;
  localparam int DW = P_VEC_W + P_LBL_W;

  logic              i_clk, i_rst_n, i_wr_en, i_start, i_mode, i_pause, i_abort;
  logic [AW-1:0]     i_wr_addr;
  logic [DW-1:0]     i_wr_data;
  logic [P_VEC_W-1:0] o_vector;
  logic [P_LBL_W-1:0] o_label;
  logic              o_valid, o_epoch_end, o_busy, o_done;
  logic [AW-1:0]     o_index;
  logic [EW-1:0]     o_epoch;

  stim_sequencer #(
    .P_VEC_W(P_VEC_W), .P_LBL_W(P_LBL_W), .P_DEPTH(P_DEPTH),
    .P_HOLD(P_HOLD), .P_GAP(P_GAP), .P_EPOCHS(P_EPOCHS)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_start(i_start), .i_mode(i_mode), .i_pause(i_pause),
    .i_abort(i_abort), .o_vector(o_vector), .o_label(o_label), .o_valid(o_valid),
    .o_index(o_index), .o_epoch(o_epoch), .o_epoch_end(o_epoch_end),
    .o_busy(o_busy), .o_done(o_done)
  );

  typedef struct packed {
    logic [P_VEC_W-1:0] vec;
    logic [P_LBL_W-1:0] lbl;
    logic               valid;
    logic [AW-1:0]      idx;
    logic [EW-1:0]      ep;
    logic               eend;
    logic               busy;
    logic               done;
  } obs_t;

  obs_t          exp_q[$];
  logic [DW-1:0] mem_m [P_DEPTH];
  bit            pause_a [0:1023];
  int            n_vec, n_err, abort_eff;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic obs_t sample();
    return {o_vector, o_label, o_valid, o_index, o_epoch, o_epoch_end, o_busy, o_done};
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [63:0] x;
    x = {$urandom(), $urandom()};
    return x[DW-1:0];
  endfunction

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
    @(posedge i_clk); #1;
    i_wr_en = 1'b0;
    if (int'(a) < P_DEPTH) mem_m[a] = d;
  endtask

  task automatic push(input logic [DW-1:0] w, input bit v, input int idx, input int ep,
                      input bit eend, input bit busy, input bit done, input bit mode);
    obs_t r;
    r.vec   = v ? w[DW-1 -: P_VEC_W] : '0;
    r.lbl   = (v && !mode) ? w[P_LBL_W-1:0] : '0;
    r.valid = v;
    r.idx   = idx[AW-1:0];
    r.ep    = ep[EW-1:0];
    r.eend  = eend;
    r.busy  = busy;
    r.done  = done;
    exp_q.push_back(r);
  endtask

  // Cycle t of the trace is the cycle following start edge E0+t.
  task automatic build(input bit mode, input int abort_at, input int wr_at,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int t, ep, cnt, passes, nbusy;
    bit eend, wdone;
    obs_t last;
    t = 0; ep = 0; eend = 0; wdone = 0;
    exp_q.delete();
    passes = mode ? 1 : P_EPOCHS;
    for (int e = 0; e < passes; e++) begin
      for (int i = 0; i < P_DEPTH; i++) begin
        cnt = 0;
        while (cnt < P_GAP) begin
          push('0, 0, i, ep, eend, 1, 0, mode);
          eend = 0;
          if (!pause_a[t]) cnt++;
          t++;
        end
        // Window data is read on the edge that opens it; writes landing on that edge are too late.
        if (!wdone && wr_at >= 0 && wr_at <= t - 2) begin
          if (int'(wa) < P_DEPTH) mem_m[wa] = wd;
          wdone = 1;
        end
        for (int h = 0; h < P_HOLD; h++) begin
          push(mem_m[i], 1, i, ep, 0, 1, 0, mode);
          t++;
        end
        if (i == P_DEPTH - 1) begin ep++; eend = 1; end
      end
    end
    nbusy = t;
    for (int k = 0; k < 4; k++) begin
      push('0, 0, P_DEPTH - 1, ep, eend, 0, 1, mode);
      eend = 0;
    end
    abort_eff = -1;
    if (abort_at >= 0 && abort_at < nbusy) begin
      abort_eff = abort_at;
      last = exp_q[abort_at];
      while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
      last.vec = '0; last.lbl = '0; last.valid = 0; last.eend = 0; last.busy = 0; last.done = 0;
      repeat (4) exp_q.push_back(last);
    end
    if (!wdone && wr_at >= 0 && wr_at < exp_q.size() && int'(wa) < P_DEPTH) mem_m[wa] = wd;
  endtask

  task automatic run(input bit mode, input int abort_at, input int wr_at,
                     input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input bit pause_en, input bit spur_start, input int rst_at);
    for (int k = 0; k < 1024; k++) pause_a[k] = pause_en && ($urandom_range(3) == 0);
    build(mode, abort_at, wr_at, wa, wd);
    i_start = 1'b1; i_mode = mode;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int t = 0; t < exp_q.size(); t++) begin
      i_pause   = pause_a[t];
      i_abort   = (t == abort_eff);
      i_wr_en   = (t == wr_at);
      i_wr_addr = wa;
      i_wr_data = wd;
      i_start   = spur_start && exp_q[t].busy && ($urandom_range(3) == 0);
      i_mode    = 1'($urandom_range(1));
      @(negedge i_clk);
      check_eq($sformatf("%s t=%0d", mode ? "test" : "train", t), 64'(sample()), 64'(exp_q[t]));
      if (t == rst_at) begin
        #2 i_rst_n = 1'b0;
        #1 check_eq("async_rst", 64'(sample()), 64'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        break;
      end
      @(posedge i_clk); #1;
    end
    i_pause = 0; i_abort = 0; i_wr_en = 0; i_start = 0;
    if (rst_at < 0 && wr_at >= exp_q.size()) load(wa, wd);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    i_rst_n = 1'b0; i_wr_en = 0; i_wr_addr = '0; i_wr_data = '0;
    i_start = 0; i_mode = 0; i_pause = 0; i_abort = 0;
    repeat (2) @(posedge i_clk);
    #1 check_eq("reset", 64'(sample()), 64'd0);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    for (int i = 0; i < P_DEPTH; i++) load(AW'(i), rnd_word());

    run(0, -1, 9, 2'd1, rnd_word(), 0, 0, -1);   // write during entry 1 read cycle
    run(1, -1, 5, 2'd3, rnd_word(), 0, 1, -1);   // test pass, out-of-range write
    run(0, -1, -1, 2'd0, '0, 1, 1, -1);          // random pause
    run(0, 22, -1, 2'd0, '0, 0, 0, -1);          // abort in first window of epoch 2
    run(0, -1, -1, 2'd0, '0, 0, 1, -1);          // restart after abort
    repeat (6) begin
      run(1'($urandom_range(1)),
          ($urandom_range(1) == 1) ? int'($urandom_range(40)) : -1,
          int'($urandom_range(45)), AW'($urandom_range(3)), rnd_word(),
          1'($urandom_range(1)), 1, -1);
    end
    run(0, -1, -1, 2'd0, '0, 0, 0, 5);           // reset in first hold window
    run(0, -1, -1, 2'd0, '0, 0, 0, -1);          // replay retained memory

    i_start = 1'b1; i_abort = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_abort = 1'b0;
    check_eq("start_abort_idle", 64'(o_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/stim_sequencer.md
# stim_sequencer

Parametrised stimulus sequencer for SNN training and test runs. It holds a writable pattern memory and replays the stored vector/label pairs. Each pattern is driven for a programmable hold window and followed by a programmable silent gap. A run is either multiple training epochs or a single unlabelled test pass. It sits in front of the network input/label ports, replaces file-loaded stimulus with a synthesizable load port, and adds start/pause/abort control and epoch reporting.

## Interface
- P_VEC_W, 25: spike vector width.
- P_LBL_W, 10: one-hot label width.
- P_DEPTH, 30: pattern memory entries per pass (>=1).
- P_HOLD, 1: cycles each pattern is driven (>=1).
- P_GAP, 200: zero cycles before each pattern (>=1).
- P_EPOCHS, 400: passes per training run (>=1).
- AW = $clog2(P_DEPTH) (min 1); EW = $clog2(P_EPOCHS+1).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_wr_en  in  1  memory write strobe.
- i_wr_addr  in  AW  write address.
- i_wr_data  in  P_VEC_W+P_LBL_W  entry; vector in MSBs, label in LSBs.
- i_start  in  1  start a run (accepted only when idle).
- i_mode  in  1  0 = train (P_EPOCHS passes), 1 = test (1 pass, label masked); sampled with i_start.
- i_pause  in  1  freezes the gap counter.
- i_abort  in  1  terminate the run.
- o_vector  out  P_VEC_W  spike vector; zero outside the hold window.
- o_label  out  P_LBL_W  label; zero outside the hold window and always zero in test mode.
- o_valid  out  1  high during the hold window.
- o_index  out  AW  address of the current or last pattern.
- o_epoch  out  EW  passes completed in this run.
- o_epoch_end  out  1  one-cycle pulse at the end of each pass.
- o_busy  out  1  run in progress.
- o_done  out  1  sticky; the run completed normally.

## Operation
- States: IDLE, GAP, HOLD.
- IDLE:
  - i_start=1 moves to GAP and sets busy.
  - It also clears o_epoch, o_index, o_done and the gap counter, and latches the mode.
- GAP:
  - Outputs are zero; the counter counts P_GAP cycles.
  - The memory read of entry o_index is issued in the last gap cycle.
  - The counter does not advance while i_pause=1.
  - On the last count, moves to HOLD.
- HOLD:
  - Drives the memory entry; o_valid=1; the hold counter counts P_HOLD cycles. i_pause is ignored, so spike width is never stretched.
  - At the end of the window, when the pattern is not last (o_index < P_DEPTH-1): increment o_index and go to GAP.
  - When the pattern is last:
    - pulse o_epoch_end and increment o_epoch.
    - If o_epoch+1 equals the target (P_EPOCHS in train, 1 in test): go to IDLE, clear busy, set o_done, keep o_index.
    - Otherwise: set o_index=0 and go to GAP.
- i_abort=1 in any state:
  - Next edge forces IDLE and zeros vector, label and valid; clears busy.
  - o_done stays 0 and o_epoch is held.
  - Abort has priority over start, the pass end and pause.
- i_start while busy is ignored. i_start together with i_abort in IDLE: abort wins and no run starts.
- Writes:
  - Accepted in any state.
  - Address >= P_DEPTH: ignored.
  - Write to the address being read in the same cycle: the read returns the old data (read-before-write).
- Memory contents are not reset.
- Counter widths are sized to reach their parameter value without wrap.

## Timing
- Reset values: every output is 0; state is IDLE.
- Start accepted at edge E0:
  - o_busy=1 from E0.
  - First o_valid rises at E0+P_GAP and stays high for P_HOLD cycles.
- Pattern period: P_GAP+P_HOLD cycles with no pause.
- Run length with no pause: (P_GAP+P_HOLD)·P_DEPTH·N cycles, N = epochs.
- Pass end:
  - o_epoch_end, the o_epoch increment and the o_valid fall occur on the same edge.
  - On the final pass, o_busy falls and o_done rises on that edge.
- Pause:
  - Each paused GAP cycle delays the next o_valid by exactly one cycle.
  - Pause asserted during HOLD takes effect at the first GAP cycle.
- Asynchronous reset mid-run: immediate return to reset values. The memory is retained.

## Test plan
- P_DEPTH=3, P_HOLD=2, P_GAP=4, P_EPOCHS=2, train mode; load entries 0..2, start at E0 -> o_valid high in cycles E0+4..5, 10..11, 16..17, 22..23, 28..29 and 34..35, with the loaded data and labels.
  - o_epoch_end pulses at E0+18 and E0+36; o_epoch reads 1, then 2.
  - o_done=1 and o_busy=0 from E0+36.
- Same setup in test mode -> 3 windows with o_label=0; o_epoch=1; o_done at E0+18.
- i_pause high for 3 cycles inside the second gap -> the second window moves to E0+13..14; with pause asserted during a hold window, that window stays exactly 2 cycles.
- i_abort during the first window of epoch 2 -> outputs are zero next edge, o_busy=0, o_done=0, o_epoch=1; a new i_start then runs from index 0.
- A write to entry 1 during its final gap read cycle -> the old value is driven; the new value is driven in the next epoch. A write to address 3 is ignored.
- i_rst_n low mid-hold -> all outputs 0 asynchronously; the stored memory replays correctly after restart.
